// File: rtl/fetch_unit.sv
// fetch_unit: owns the program counter and the IF/ID pipeline register.
// Picks the next PC from redirect, stall, BLT prediction or sequential
// fetch, and tags each fetched instruction with its prediction so the
// execute stage can verify it.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef NUM_PIPE_MASKS
`define NUM_PIPE_MASKS 4
`endif
`ifndef PIPE_REG_PC
`define PIPE_REG_PC 0
`endif
`ifndef PIPE_REG_IF_ID
`define PIPE_REG_IF_ID 1
`endif

module fetch_unit #(
  parameter int ADDR_WIDTH     = `ADDR_WIDTH,
  parameter int INST_WIDTH     = 32,
  parameter int NUM_PIPE_MASKS = `NUM_PIPE_MASKS,
  parameter int RESET_PC       = 0,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_PIPE_MASKS-1:0] flush,
  input  logic [ADDR_WIDTH-1:0]     jump_address,
  input  logic                      stall,
  input  logic                      take_branch,
  input  logic [ADDR_WIDTH-1:0]     branch_predict,
  input  logic [INST_WIDTH-1:0]     instruction,
  output logic [ADDR_WIDTH-1:0]     pc,
  output logic                      if_id_valid,
  output logic [ADDR_WIDTH-1:0]     if_id_pc,
  output logic [INST_WIDTH-1:0]     if_id_instruction,
  output logic                      if_id_branch_taken,
  output logic [ADDR_WIDTH-1:0]     if_id_branch_taken_address,
  output logic [CNT_WIDTH-1:0]      fetch_count,
  output logic [CNT_WIDTH-1:0]      redirect_count
);

  localparam logic [ADDR_WIDTH-1:0] PC_ONE    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PC_RESET  = ADDR_WIDTH'(RESET_PC);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

  logic                  fpc;
  logic                  fid;
  logic                  if_id_load;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic                  unused_flush;

  assign fpc          = flush[`PIPE_REG_PC];
  assign fid          = flush[`PIPE_REG_IF_ID];
  // Other flush bits belong to later stages and are intentionally ignored.
  assign unused_flush = ^flush;
  assign if_id_load   = !fid && !stall;

  // Next-PC selection: redirect, then stall hold, then prediction, then pc+1.
  always_comb begin
    pc_next = pc + PC_ONE;
    if (fpc)
      pc_next = jump_address;
    else if (stall)
      pc_next = pc;
    else if (take_branch)
      pc_next = branch_predict;
  end

  // Program counter register.
  always_ff @(posedge clk) begin
    if (reset)
      pc <= PC_RESET;
    else
      pc <= pc_next;
  end

  // IF/ID register: flush clears it even while stalled (wrong-path instruction).
  always_ff @(posedge clk) begin
    if (reset || fid) begin
      if_id_valid                <= 1'b0;
      if_id_pc                   <= '0;
      if_id_instruction          <= '0;
      if_id_branch_taken         <= 1'b0;
      if_id_branch_taken_address <= '0;
    end else if (!stall) begin
      if_id_valid                <= 1'b1;
      if_id_pc                   <= pc;
      if_id_instruction          <= instruction;
      if_id_branch_taken         <= take_branch;
      if_id_branch_taken_address <= take_branch ? branch_predict : '0;
    end
  end

  // Saturating statistics counters; never wrap back to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count    <= '0;
      redirect_count <= '0;
    end else begin
      if (if_id_load && fetch_count != CNT_MAX)
        fetch_count <= fetch_count + CNT_ONE;
      if (fpc && redirect_count != CNT_MAX)
        redirect_count <= redirect_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: table-driven vectors with a scoreboard queue,
// plus a second instance with narrow counters for saturation.

module tb_fetch_unit;

  localparam int AW = 16;
  localparam int IW = 32;
  localparam int NM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance signals
  logic          reset;
  logic [NM-1:0] flush;
  logic [AW-1:0] jump_address;
  logic          stall;
  logic          take_branch;
  logic [AW-1:0] branch_predict;
  logic [IW-1:0] instruction;
  logic [AW-1:0] pc;
  logic          if_id_valid;
  logic [AW-1:0] if_id_pc;
  logic [IW-1:0] if_id_instruction;
  logic          if_id_branch_taken;
  logic [AW-1:0] if_id_branch_taken_address;
  logic [15:0]   fetch_count;
  logic [15:0]   redirect_count;

  // imem model: instruction word derived from its address
  assign instruction = {16'hBEEF, pc};

  fetch_unit #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .NUM_PIPE_MASKS(NM),
               .RESET_PC(0), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .jump_address(jump_address),
    .stall(stall), .take_branch(take_branch), .branch_predict(branch_predict),
    .instruction(instruction), .pc(pc), .if_id_valid(if_id_valid),
    .if_id_pc(if_id_pc), .if_id_instruction(if_id_instruction),
    .if_id_branch_taken(if_id_branch_taken),
    .if_id_branch_taken_address(if_id_branch_taken_address),
    .fetch_count(fetch_count), .redirect_count(redirect_count)
  );

  // saturation instance signals
  logic          s_reset;
  logic [NM-1:0] s_flush;
  logic [AW-1:0] s_jump;
  logic          s_stall;
  logic          s_take;
  logic [AW-1:0] s_pred;
  logic [IW-1:0] s_instr;
  logic [AW-1:0] s_pc;
  logic          s_valid;
  logic [AW-1:0] s_ipc;
  logic [IW-1:0] s_iinstr;
  logic          s_bt;
  logic [AW-1:0] s_ba;
  logic [3:0]    s_fc;
  logic [3:0]    s_rc;

  assign s_instr = {16'h5A5A, s_pc};

  fetch_unit #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .NUM_PIPE_MASKS(NM),
               .RESET_PC(0), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .reset(s_reset), .flush(s_flush), .jump_address(s_jump),
    .stall(s_stall), .take_branch(s_take), .branch_predict(s_pred),
    .instruction(s_instr), .pc(s_pc), .if_id_valid(s_valid),
    .if_id_pc(s_ipc), .if_id_instruction(s_iinstr),
    .if_id_branch_taken(s_bt), .if_id_branch_taken_address(s_ba),
    .fetch_count(s_fc), .redirect_count(s_rc)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  fl;
    logic [15:0] jmp;
    logic        st;
    logic        tk;
    logic [15:0] pr;
    logic [15:0] e_pc;
    logic        e_v;
    logic [15:0] e_ipc;
    logic        e_bt;
    logic [15:0] e_ba;
    logic [15:0] e_fc;
    logic [15:0] e_rc;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];
  vec_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t e;
    string tag;

    //         rst fl   jmp      st tk pr       pc       v  ipc      bt ba       fc  rc
    vecs[0]  = '{1, 0,   0,       0, 0, 0,       0,       0, 0,       0, 0,       0,  0};
    vecs[1]  = '{0, 0,   0,       0, 0, 0,       1,       1, 0,       0, 0,       1,  0};
    vecs[2]  = '{0, 0,   0,       0, 0, 0,       2,       1, 1,       0, 0,       2,  0};
    vecs[3]  = '{0, 0,   0,       0, 0, 0,       3,       1, 2,       0, 0,       3,  0};
    vecs[4]  = '{0, 0,   0,       0, 0, 0,       4,       1, 3,       0, 0,       4,  0};
    vecs[5]  = '{0, 0,   0,       0, 0, 0,       5,       1, 4,       0, 0,       5,  0};
    vecs[6]  = '{0, 0,   0,       0, 1, 'h20,    'h20,    1, 5,       1, 'h20,    6,  0};
    vecs[7]  = '{0, 0,   0,       0, 0, 0,       'h21,    1, 'h20,    0, 0,       7,  0};
    vecs[8]  = '{0, 3,   6,       0, 0, 0,       6,       0, 0,       0, 0,       7,  1};
    vecs[9]  = '{0, 0,   0,       0, 0, 0,       7,       1, 6,       0, 0,       8,  1};
    vecs[10] = '{0, 0,   0,       1, 0, 0,       7,       1, 6,       0, 0,       8,  1};
    vecs[11] = '{0, 0,   0,       1, 1, 'h30,    7,       1, 6,       0, 0,       8,  1};
    vecs[12] = '{0, 0,   0,       1, 0, 0,       7,       1, 6,       0, 0,       8,  1};
    vecs[13] = '{0, 0,   0,       0, 0, 0,       8,       1, 7,       0, 0,       9,  1};
    vecs[14] = '{0, 0,   0,       0, 0, 0,       9,       1, 8,       0, 0,       10, 1};
    vecs[15] = '{0, 'hF, 'h40,    1, 0, 0,       'h40,    0, 0,       0, 0,       10, 2};
    vecs[16] = '{0, 0,   0,       0, 0, 0,       'h41,    1, 'h40,    0, 0,       11, 2};
    vecs[17] = '{0, 1,   'hFFFF,  0, 0, 0,       'hFFFF,  1, 'h41,    0, 0,       12, 3};
    vecs[18] = '{0, 0,   0,       0, 0, 0,       0,       1, 'hFFFF,  0, 0,       13, 3};
    vecs[19] = '{0, 1,   'h60,    0, 1, 'h50,    'h60,    1, 0,       1, 'h50,    14, 4};
    vecs[20] = '{1, 3,   'h77,    1, 1, 'h50,    0,       0, 0,       0, 0,       0,  0};
    vecs[21] = '{0, 0,   0,       0, 0, 0,       1,       1, 0,       0, 0,       1,  0};

    reset = 1'b1; flush = '0; jump_address = '0; stall = 1'b0;
    take_branch = 1'b0; branch_predict = '0;
    s_reset = 1'b1; s_flush = '0; s_jump = '0; s_stall = 1'b0;
    s_take = 1'b0; s_pred = '0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      reset          = vecs[i].rst;
      flush          = vecs[i].fl;
      jump_address   = vecs[i].jmp;
      stall          = vecs[i].st;
      take_branch    = vecs[i].tk;
      branch_predict = vecs[i].pr;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      tag = $sformatf("v%0d", i);
      check({tag, " pc"},        32'(pc),                         32'(e.e_pc));
      check({tag, " valid"},     32'(if_id_valid),                32'(e.e_v));
      check({tag, " if_id_pc"},  32'(if_id_pc),                   32'(e.e_ipc));
      check({tag, " instr"},     if_id_instruction,
            e.e_v ? {16'hBEEF, e.e_ipc} : 32'h0);
      check({tag, " bt"},        32'(if_id_branch_taken),         32'(e.e_bt));
      check({tag, " bt_addr"},   32'(if_id_branch_taken_address), 32'(e.e_ba));
      check({tag, " fetch_cnt"}, 32'(fetch_count),                32'(e.e_fc));
      check({tag, " redir_cnt"}, 32'(redirect_count),             32'(e.e_rc));
    end
    if (sb.size() != 0) check("sb_drain", 32'(sb.size()), 32'd0);

    // Saturation with 4-bit counters: 20 consecutive PC-only redirects.
    @(negedge clk);
    s_reset = 1'b0;
    s_flush = 4'b0001;
    for (int r = 1; r <= 20; r++) begin
      s_jump = AW'(16'h100 + r);
      @(posedge clk);
      #1;
      if (r == 14) check("sat rc@14", 32'(s_rc), 32'd14);
      if (r == 15) check("sat rc@15", 32'(s_rc), 32'd15);
      if (r == 20) begin
        check("sat rc@20", 32'(s_rc), 32'd15);
        check("sat fc@20", 32'(s_fc), 32'd15);
        check("sat pc@20", 32'(s_pc), 32'h114);
      end
      @(negedge clk);
    end

    // Reset coinciding with flush and stall.
    s_reset = 1'b1;
    s_flush = 4'b1111;
    s_stall = 1'b1;
    s_jump  = 16'h0ABC;
    @(posedge clk);
    #1;
    check("rst pc",    32'(s_pc),    32'd0);
    check("rst rc",    32'(s_rc),    32'd0);
    check("rst fc",    32'(s_fc),    32'd0);
    check("rst valid", 32'(s_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
